alu_iter: RTL
=============

Name: alu_iter

Overview:
- Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU decoder, plus the SrcA/SrcB operands, and produces ALUResult and Zero.
- Logic and arithmetic ops take 1 cycle. Shifts iterate one bit per cycle to save area.
- Valid/ready handshakes on both sides let the surrounding datapath stall while a shift is in progress.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width (log2 WIDTH); shift count = SrcB[SHAMT_W-1:0], upper bits of SrcB ignored.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- ALUControl  input  4  op code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt, 0110 xor, 0111 srl, 1000 sra.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B / shift amount.
- out_valid  output  1  ALUResult/Zero valid.
- out_ready  input  1  consumer accepts result.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered, 1 iff ALUResult == 0.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, ALUResult=0, Zero=0, internal counter=0. in_ready=0 while reset is high.
- Reset mid-shift or with out_valid high aborts the operation; no result is emitted.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This gives back-to-back throughput of 1 op/cycle for non-shift ops.
- Accept = in_valid & in_ready. ALUControl, SrcA and SrcB are sampled only on accept; later changes are ignored.
- Non-shift op on accept: result computed and registered; state -> DONE. out_valid is high the next cycle (latency 1).
  - add/sub wrap modulo 2^WIDTH.
  - and/or/xor bitwise.
  - slt: signed compare, result 1 if SrcA<SrcB else 0, zero-extended.
  - Codes 1001-1111: result 0, Zero=1.
- Shift op with count N=0: ALUResult=SrcA, latency 1, same as a non-shift op.
- Shift op with N>0:
  - On accept: acc<=SrcA, cnt<=N, state -> SHIFT.
  - Each SHIFT cycle: acc shifts 1 bit and cnt decrements.
    - sll: <<1, fill 0.
    - srl: >>1, fill 0.
    - sra: >>1, fill acc[WIDTH-1].
  - When cnt==1 at the edge: ALUResult<=shifted acc, Zero updated, state -> DONE.
  - Latency N+1 cycles from accept to out_valid.
- SHIFT state: in_ready=0, out_valid=0. ALUResult holds its previous value until DONE.
- DONE state:
  - out_valid=1; ALUResult and Zero are held stable until out_ready.
  - out_ready & no new accept -> IDLE, out_valid=0.
  - out_ready & accept in the same cycle -> new op is processed as if from IDLE.
  - out_ready=0 -> remain in DONE indefinitely.
- Simultaneous reset with in_valid: reset wins; the request is dropped.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- Defined: sll/srl/sra use a single-cycle barrel shifter, the SHIFT state is unused, and all ops have latency 1 with in_ready never deasserted for shifts.
- Undefined: iterative shifter as above (latency N+1).
- All results are bit-identical in both builds.

Test Plan:
- Add: SrcA=0x7FFFFFFF, SrcB=1, ALUControl=0000 -> 1 cycle later out_valid=1, ALUResult=0x80000000, Zero=0.
- Sub/slt: sub 5-5 -> ALUResult=0, Zero=1. slt SrcA=0xFFFFFFFF (-1), SrcB=1 -> ALUResult=1.
- Sra: SrcA=0x80000000, SrcB=0x0000001F, ALUControl=1000 -> in_ready low 31 cycles, out_valid at cycle 32, ALUResult=0xFFFFFFFF. With ALU_BARREL_SHIFT_EN: cycle 1, same value.
- Shift count 0 and upper SrcB ignored: sll SrcA=0x1234, SrcB=0x20 -> latency 1, ALUResult=0x1234. srl SrcA=0x80000000, SrcB=4 -> 0x08000000 at cycle 5.
- Backpressure/throughput:
  - Hold out_ready=0 for 3 cycles after xor 0xF0F0^0x0FF0 -> ALUResult=0xFF00 stable, in_ready=0.
  - Then out_ready=1 with a new or request -> result accepted and new op accepted in the same cycle.
- Reset mid-shift: sll N=10, assert reset at cycle 4 -> out_valid stays 0, ALUResult=0.
  - Next op (and 0xFF&0x0F) -> 0x0F at latency 1.

Source files
------------

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle logic/arithmetic, shifts iterate one bit per cycle.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module alu_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ALUControl,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic                 accept;
  logic                 start_shift;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     comb_result;

  assign shamt       = SrcB[SHAMT_W-1:0];
  assign in_ready    = !reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == DONE);

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b0111) || (op == 4'b1000);
  endfunction

`ifdef ALU_BARREL_SHIFT_EN
  function automatic logic [WIDTH-1:0] shift_full(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [SHAMT_W-1:0] sh);
    logic signed [WIDTH-1:0] sa;
    sa = a;
    case (op)
      4'b0100: return a << sh;
      4'b0111: return a >> sh;
      default: return WIDTH'(sa >>> sh);
    endcase
  endfunction
`else
  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a);
    case (op)
      4'b0100: return {a[WIDTH-2:0], 1'b0};
      4'b0111: return {1'b0, a[WIDTH-1:1]};
      default: return {a[WIDTH-1], a[WIDTH-1:1]};
    endcase
  endfunction
`endif

  // Everything that completes in the accept cycle; shifts reaching here are either
  // barrel shifts or zero-count iterative shifts (which pass SrcA through).
  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0101: return {{(WIDTH-1){1'b0}}, (sa < sb)};
      4'b0110: return a ^ b;
`ifdef ALU_BARREL_SHIFT_EN
      4'b0100, 4'b0111, 4'b1000: return shift_full(op, a, b[SHAMT_W-1:0]);
`else
      4'b0100, 4'b0111, 4'b1000: return a;
`endif
      default: return '0;
    endcase
  endfunction

  assign comb_result = alu_op(ALUControl, SrcA, SrcB);

`ifdef ALU_BARREL_SHIFT_EN
  assign start_shift = 1'b0;
`else
  logic [WIDTH-1:0]   acc_p1;
  logic [WIDTH-1:0]   acc_nxt;
  logic [SHAMT_W-1:0] cnt_p1;
  logic [3:0]         sop_p1;

  assign start_shift = is_shift_op(ALUControl) && (shamt != '0);
  assign acc_nxt     = shift_one(sop_p1, acc_p1);
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept)                              state_d = start_shift ? SHIFT : DONE;
        else if ((state_q == DONE) && out_ready) state_d = IDLE;
      end
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: if (cnt_p1 == SHAMT_W'(1)) state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Result stage: written on accept (single-cycle ops) or on the last shift step
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult <= '0;
      Zero      <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      cnt_p1    <= '0;
`endif
    end else if (accept && !start_shift) begin
      ALUResult <= comb_result;
      Zero      <= (comb_result == '0);
`ifndef ALU_BARREL_SHIFT_EN
    end else if (accept) begin
      acc_p1    <= SrcA;
      cnt_p1    <= shamt;
      sop_p1    <= ALUControl;
    end else if (state_q == SHIFT) begin
      acc_p1    <= acc_nxt;
      cnt_p1    <= cnt_p1 - SHAMT_W'(1);
      if (cnt_p1 == SHAMT_W'(1)) begin
        ALUResult <= acc_nxt;
        Zero      <= (acc_nxt == '0);
      end
`endif
    end
  end

endmodule
